// File: rtl/tinyqv_fetch_buffer.sv
// tinyqv_fetch_buffer
// Instruction prefetch buffer between the QSPI controller's instruction port
// and the CPU decoder. Halfwords returned by the controller are queued in a
// small FIFO and presented to the decoder as complete instructions with PC.
// A jump flushes the FIFO and redirects the fetch stream.
//
// Optional feature macro: TQV_FETCH_RVC_EN
//   defined   : 16-bit compressed and 32-bit instructions are assembled.
//   undefined : every instruction is treated as 32 bits.
module tinyqv_fetch_buffer #(
  parameter int          DEPTH      = 4,
  parameter logic [22:0] RESET_ADDR = 23'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump,
  input  logic [22:0] jump_addr,
  input  logic        instr_take,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [22:0] instr_pc,
  output logic [22:0] instr_addr,
  output logic        instr_fetch_restart,
  output logic        instr_fetch_stall,
  input  logic        instr_fetch_started,
  input  logic        instr_fetch_stopped,
  input  logic [15:0] instr_data,
  input  logic        instr_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t        state;
  logic [15:0]   fifo [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [22:0]   fetch_addr;
  logic [22:0]   pc;

  logic [15:0]   head;
  logic [15:0]   head_nxt;
  logic          is_rvc;
  logic          full;
  logic          push_en;
  logic          pop_en;
  logic [CW-1:0] pop_amt;

  assign head     = fifo[rd_ptr];
  assign head_nxt = fifo[rd_ptr + PW'(1)];
  assign full     = (count == CW'(DEPTH));

`ifdef TQV_FETCH_RVC_EN
  assign is_rvc = (head[1:0] != 2'b11);
`else
  assign is_rvc = 1'b0;
`endif

  // Written so that an uninitialised head never leaks into valid when empty.
  assign instr_valid = (count >= CW'(2)) || ((count == CW'(1)) && is_rvc);
  assign instr_out   = !instr_valid ? 32'h0 :
                       is_rvc       ? {16'h0, head} :
                                      {head_nxt, head};

  assign instr_pc          = pc;
  assign instr_addr        = fetch_addr;
  assign instr_fetch_stall = full;

  // Halfwords are only taken while a fetch is streaming; a full FIFO drops them.
  assign push_en = (state == ST_RUN) && instr_ready && !jump && !full;
  assign pop_en  = instr_take && instr_valid && !jump;
  assign pop_amt = !pop_en ? '0 : (is_rvc ? CW'(1) : CW'(2));

  // Fetch sequencing: request, stream, and re-request after pre-emption or jump.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= ST_IDLE;
      instr_fetch_restart <= 1'b0;
    end else if (jump) begin
      state               <= ST_REQ;
      instr_fetch_restart <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!full) begin
            state               <= ST_REQ;
            instr_fetch_restart <= 1'b1;
          end
        end
        ST_REQ: begin
          if (instr_fetch_started) begin
            state               <= ST_RUN;
            instr_fetch_restart <= 1'b0;
          end
        end
        ST_RUN: begin
          if (instr_fetch_stopped) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state               <= ST_IDLE;
          instr_fetch_restart <= 1'b0;
        end
      endcase
    end
  end

  // FIFO bookkeeping, fetch address and PC; a jump flushes and redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      fetch_addr <= RESET_ADDR;
      pc         <= RESET_ADDR;
    end else if (jump) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      fetch_addr <= jump_addr;
      pc         <= jump_addr;
    end else begin
      count      <= count + CW'(push_en) - pop_amt;
      rd_ptr     <= rd_ptr + pop_amt[PW-1:0];
      wr_ptr     <= wr_ptr + PW'(push_en);
      fetch_addr <= fetch_addr + 23'(push_en);
      pc         <= pc + 23'(pop_amt);
    end
  end

  // Halfword storage; contents are qualified by count so need no reset.
  always_ff @(posedge clk) begin
    if (push_en) begin
      fifo[wr_ptr] <= instr_data;
    end
  end

endmodule

// File: tb/tb_tinyqv_fetch_buffer.sv
// Testbench for tinyqv_fetch_buffer: directed scenarios plus a randomized run
// with a controller emulator, checked against a queue-based reference model.
module tb_tinyqv_fetch_buffer;

  localparam int          DEPTH = 4;
  localparam logic [22:0] RA    = 23'h000040;
  localparam int M_IDLE = 0, M_REQ = 1, M_RUN = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump = 1'b0;
  logic [22:0] jump_addr = '0;
  logic        instr_take = 1'b0;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [22:0] instr_pc;
  logic [22:0] instr_addr;
  logic        instr_fetch_restart;
  logic        instr_fetch_stall;
  logic        instr_fetch_started = 1'b0;
  logic        instr_fetch_stopped = 1'b0;
  logic [15:0] instr_data = '0;
  logic        instr_ready = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  // reference model
  logic [15:0] m_q[$];
  logic [22:0] m_pc, m_fa;
  int          m_mode;

  tinyqv_fetch_buffer #(.DEPTH(DEPTH), .RESET_ADDR(RA)) dut (
    .clk(clk), .rst(rst), .jump(jump), .jump_addr(jump_addr),
    .instr_take(instr_take), .instr_valid(instr_valid), .instr_out(instr_out),
    .instr_pc(instr_pc), .instr_addr(instr_addr),
    .instr_fetch_restart(instr_fetch_restart), .instr_fetch_stall(instr_fetch_stall),
    .instr_fetch_started(instr_fetch_started), .instr_fetch_stopped(instr_fetch_stopped),
    .instr_data(instr_data), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  function automatic int m_len();
`ifdef TQV_FETCH_RVC_EN
    if (m_q.size() > 0 && m_q[0][1:0] != 2'b11) return 1;
`endif
    return 2;
  endfunction

  function automatic bit m_valid();
    return m_q.size() >= m_len();
  endfunction

  function automatic logic [31:0] m_out();
    if (m_len() == 1) return {16'h0, m_q[0]};
    return {m_q[1], m_q[0]};
  endfunction

  // Memory image served by the emulated controller.
  function automatic logic [15:0] memf(input logic [22:0] a);
    logic [15:0] h;
    h = a[15:0] ^ {a[22:16], 9'h0};
    return h * 16'h9E37 + 16'h1234;
  endfunction

  // Instruction the decoder should see at PC a, straight from the memory image.
  function automatic logic [31:0] mem_instr(input logic [22:0] a);
`ifdef TQV_FETCH_RVC_EN
    if (memf(a)[1:0] != 2'b11) return {16'h0, memf(a)};
`endif
    return {memf(a + 23'd1), memf(a)};
  endfunction

  task automatic m_update();
    int sz;
    int pops;
    bit acc;
    if (rst) begin
      m_q.delete(); m_pc = RA; m_fa = RA; m_mode = M_IDLE;
    end else if (jump) begin
      m_q.delete(); m_pc = jump_addr; m_fa = jump_addr; m_mode = M_REQ;
    end else begin
      sz   = m_q.size();
      acc  = (m_mode == M_RUN) && instr_ready && (sz < DEPTH);
      pops = (instr_take && m_valid()) ? m_len() : 0;
      repeat (pops) void'(m_q.pop_front());
      m_pc = m_pc + 23'(pops);
      if (acc) begin
        m_q.push_back(instr_data);
        m_fa = m_fa + 23'd1;
      end
      case (m_mode)
        M_IDLE:  if (sz < DEPTH) m_mode = M_REQ;
        M_REQ:   if (instr_fetch_started) m_mode = M_RUN;
        default: if (instr_fetch_stopped) m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic tick();
    m_update();
    @(posedge clk);
    #1;
    jump = 1'b0; instr_take = 1'b0; instr_ready = 1'b0;
    instr_fetch_started = 1'b0; instr_fetch_stopped = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    compared++; if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    compared++; if (instr_out !== 32'h0) begin mismatched++; $display("FAIL reset_out: got %h want 0", instr_out); end
    compared++; if (instr_fetch_restart !== 1'b0) begin mismatched++; $display("FAIL reset_restart: got %b want 0", instr_fetch_restart); end
    compared++; if (instr_fetch_stall !== 1'b0) begin mismatched++; $display("FAIL reset_stall: got %b want 0", instr_fetch_stall); end
    compared++; if (instr_addr !== RA) begin mismatched++; $display("FAIL reset_addr: got %h want %h", instr_addr, RA); end
    compared++; if (instr_pc !== RA) begin mismatched++; $display("FAIL reset_pc: got %h want %h", instr_pc, RA); end
    rst = 1'b0;
    for (int n = 0; n < 4 && instr_fetch_restart !== 1'b1; n++) tick();
    compared++; if (instr_fetch_restart !== 1'b1) begin mismatched++; $display("FAIL reset_first_restart: got %b want 1", instr_fetch_restart); end
  endtask

  task automatic test_nop32();
    instr_fetch_started = 1'b1; tick();
    instr_ready = 1'b1; instr_data = 16'h0013; tick();
    instr_ready = 1'b1; instr_data = 16'h0000; tick();
    compared++; if (instr_valid !== 1'b1) begin mismatched++; $display("FAIL nop_valid: got %b want 1", instr_valid); end
    compared++; if (instr_out !== 32'h00000013) begin mismatched++; $display("FAIL nop_out: got %h want 00000013", instr_out); end
    compared++; if (instr_pc !== RA) begin mismatched++; $display("FAIL nop_pc: got %h want %h", instr_pc, RA); end
    instr_take = 1'b1; tick();
    compared++; if (instr_pc !== RA + 23'd2) begin mismatched++; $display("FAIL nop_pc_after: got %h want %h", instr_pc, RA + 23'd2); end
    compared++; if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL nop_valid_after: got %b want 0", instr_valid); end
  endtask

  task automatic test_rvc();
    jump = 1'b1; jump_addr = 23'h000200; tick();
    instr_fetch_started = 1'b1; tick();
    instr_ready = 1'b1; instr_data = 16'h4501; tick();
    instr_ready = 1'b1; instr_data = 16'h0001; tick();
`ifdef TQV_FETCH_RVC_EN
    compared++; if (instr_out !== 32'h00004501 || instr_valid !== 1'b1) begin mismatched++; $display("FAIL rvc_first: got %h want 00004501", instr_out); end
    compared++; if (instr_pc !== 23'h000200) begin mismatched++; $display("FAIL rvc_pc0: got %h want 000200", instr_pc); end
    instr_take = 1'b1; tick();
    compared++; if (instr_out !== 32'h00000001 || instr_valid !== 1'b1) begin mismatched++; $display("FAIL rvc_second: got %h want 00000001", instr_out); end
    compared++; if (instr_pc !== 23'h000201) begin mismatched++; $display("FAIL rvc_pc1: got %h want 000201", instr_pc); end
    instr_take = 1'b1; tick();
`else
    compared++; if (instr_out !== 32'h00014501 || instr_valid !== 1'b1) begin mismatched++; $display("FAIL rvc_off_out: got %h want 00014501", instr_out); end
    compared++; if (instr_pc !== 23'h000200) begin mismatched++; $display("FAIL rvc_off_pc0: got %h want 000200", instr_pc); end
    instr_take = 1'b1; tick();
`endif
    compared++; if (instr_pc !== 23'h000202) begin mismatched++; $display("FAIL rvc_pc_end: got %h want 000202", instr_pc); end
    compared++; if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL rvc_empty: got %b want 0", instr_valid); end
  endtask

  task automatic test_jump_run();
    jump = 1'b1; jump_addr = 23'h000300; tick();
    instr_fetch_started = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin instr_ready = 1'b1; instr_data = 16'h0003 + 16'(i); tick(); end
    compared++; if (instr_addr !== 23'h000303) begin mismatched++; $display("FAIL jr_addr3: got %h want 000303", instr_addr); end
    jump = 1'b1; jump_addr = 23'h001000; instr_ready = 1'b1; instr_data = 16'hDEAD; tick();
    compared++; if (instr_valid !== 1'b0 || instr_fetch_stall !== 1'b0) begin mismatched++; $display("FAIL jr_flush: got valid %b stall %b want 0 0", instr_valid, instr_fetch_stall); end
    compared++; if (instr_pc !== 23'h001000 || instr_addr !== 23'h001000) begin mismatched++; $display("FAIL jr_redirect: got pc %h addr %h want 001000", instr_pc, instr_addr); end
    compared++; if (instr_fetch_restart !== 1'b1) begin mismatched++; $display("FAIL jr_restart: got %b want 1", instr_fetch_restart); end
    instr_ready = 1'b1; instr_data = 16'hBEEF; tick();
    compared++; if (instr_addr !== 23'h001000 || instr_valid !== 1'b0) begin mismatched++; $display("FAIL jr_discard: got addr %h valid %b want 001000 0", instr_addr, instr_valid); end
    jump = 1'b1; jump_addr = 23'h001000; instr_fetch_started = 1'b1; tick();
    compared++; if (instr_fetch_restart !== 1'b1) begin mismatched++; $display("FAIL jr_stale_started: got %b want 1", instr_fetch_restart); end
    instr_ready = 1'b1; instr_data = 16'hBEEF; tick();
    compared++; if (instr_addr !== 23'h001000) begin mismatched++; $display("FAIL jr_discard_req: got %h want 001000", instr_addr); end
    instr_fetch_started = 1'b1; tick();
    compared++; if (instr_fetch_restart !== 1'b0 || instr_addr !== 23'h001000) begin mismatched++; $display("FAIL jr_run: got restart %b addr %h want 0 001000", instr_fetch_restart, instr_addr); end
    instr_ready = 1'b1; instr_data = 16'h0013; tick();
    instr_ready = 1'b1; instr_data = 16'h0000; tick();
    compared++; if (instr_out !== 32'h00000013 || instr_pc !== 23'h001000 || instr_addr !== 23'h001002) begin mismatched++; $display("FAIL jr_fetch: got out %h pc %h addr %h want 00000013 001000 001002", instr_out, instr_pc, instr_addr); end
  endtask

  task automatic test_stall();
    logic [15:0] hw [4];
    hw[0] = 16'h1003; hw[1] = 16'h1111; hw[2] = 16'h2003; hw[3] = 16'h2222;
    jump = 1'b1; jump_addr = 23'h000400; tick();
    instr_fetch_started = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin
      instr_ready = 1'b1; instr_data = hw[i]; tick();
      if (i == 2) begin
        compared++; if (instr_fetch_stall !== 1'b0) begin mismatched++; $display("FAIL stall_early: got %b want 0", instr_fetch_stall); end
      end
    end
    compared++; if (instr_fetch_stall !== 1'b1 || instr_addr !== 23'h000404) begin mismatched++; $display("FAIL stall_full: got stall %b addr %h want 1 000404", instr_fetch_stall, instr_addr); end
    instr_ready = 1'b1; instr_data = 16'hFFFF; tick();
    compared++; if (instr_fetch_stall !== 1'b1 || instr_addr !== 23'h000404) begin mismatched++; $display("FAIL stall_drop: got stall %b addr %h want 1 000404", instr_fetch_stall, instr_addr); end
    instr_take = 1'b1; tick();
    compared++; if (instr_fetch_stall !== 1'b0 || instr_pc !== 23'h000402) begin mismatched++; $display("FAIL stall_release: got stall %b pc %h want 0 000402", instr_fetch_stall, instr_pc); end
    compared++; if (instr_out !== 32'h22222003 || instr_valid !== 1'b1) begin mismatched++; $display("FAIL stall_next: got %h want 22222003", instr_out); end
  endtask

  task automatic test_stopped();
    jump = 1'b1; jump_addr = 23'h000500; tick();
    instr_fetch_started = 1'b1; tick();
    instr_ready = 1'b1; instr_data = 16'hA003; tick();
    instr_ready = 1'b1; instr_data = 16'h000A; tick();
    instr_fetch_stopped = 1'b1; tick();
    compared++; if (instr_fetch_restart !== 1'b0 || instr_addr !== 23'h000502) begin mismatched++; $display("FAIL stop_idle: got restart %b addr %h want 0 000502", instr_fetch_restart, instr_addr); end
    tick();
    compared++; if (instr_fetch_restart !== 1'b1 || instr_addr !== 23'h000502) begin mismatched++; $display("FAIL stop_req: got restart %b addr %h want 1 000502", instr_fetch_restart, instr_addr); end
    instr_fetch_stopped = 1'b1; instr_ready = 1'b1; instr_data = 16'hEEEE; tick();
    compared++; if (instr_fetch_restart !== 1'b1 || instr_addr !== 23'h000502) begin mismatched++; $display("FAIL stop_ignored: got restart %b addr %h want 1 000502", instr_fetch_restart, instr_addr); end
    instr_fetch_started = 1'b1; tick();
    instr_ready = 1'b1; instr_data = 16'hB003; tick();
    instr_ready = 1'b1; instr_data = 16'h000B; tick();
    compared++; if (instr_out !== 32'h000AA003 || instr_pc !== 23'h000500) begin mismatched++; $display("FAIL stop_first: got %h pc %h want 000aa003 000500", instr_out, instr_pc); end
    instr_take = 1'b1; tick();
    compared++; if (instr_out !== 32'h000BB003 || instr_pc !== 23'h000502) begin mismatched++; $display("FAIL stop_resume: got %h pc %h want 000bb003 000502", instr_out, instr_pc); end
    instr_take = 1'b1; tick();
    compared++; if (instr_valid !== 1'b0 || instr_pc !== 23'h000504 || instr_addr !== 23'h000504) begin mismatched++; $display("FAIL stop_end: got valid %b pc %h addr %h want 0 000504 000504", instr_valid, instr_pc, instr_addr); end
  endtask

  task automatic test_wrap();
    jump = 1'b1; jump_addr = 23'h7FFFFF; tick();
    instr_fetch_started = 1'b1; tick();
    instr_ready = 1'b1; instr_data = 16'h0001; tick();
    instr_ready = 1'b1; instr_data = 16'h0002; tick();
    compared++; if (instr_addr !== 23'h000001) begin mismatched++; $display("FAIL wrap_addr: got %h want 000001", instr_addr); end
    compared++; if (instr_pc !== 23'h7FFFFF) begin mismatched++; $display("FAIL wrap_pc0: got %h want 7fffff", instr_pc); end
`ifdef TQV_FETCH_RVC_EN
    compared++; if (instr_out !== 32'h00000001) begin mismatched++; $display("FAIL wrap_out: got %h want 00000001", instr_out); end
    instr_take = 1'b1; tick();
    compared++; if (instr_pc !== 23'h000000 || instr_out !== 32'h00000002) begin mismatched++; $display("FAIL wrap_pc1: got pc %h out %h want 000000 00000002", instr_pc, instr_out); end
`else
    compared++; if (instr_out !== 32'h00020001) begin mismatched++; $display("FAIL wrap_out: got %h want 00020001", instr_out); end
    instr_take = 1'b1; tick();
    compared++; if (instr_pc !== 23'h000001) begin mismatched++; $display("FAIL wrap_pc1: got %h want 000001", instr_pc); end
`endif
  endtask

  task automatic test_random();
    bit          ctrl_on;
    bit          was_on;
    bit          pend_stop;
    logic [22:0] ctrl_addr;
    ctrl_on = 1'b0; pend_stop = 1'b0; ctrl_addr = '0;
    jump = 1'b1; jump_addr = 23'($urandom); tick();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      compared++; if (instr_valid !== m_valid()) begin mismatched++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, instr_valid, m_valid()); end
      compared++; if (instr_pc !== m_pc) begin mismatched++; $display("FAIL rnd_pc@%0d: got %h want %h", cyc, instr_pc, m_pc); end
      compared++; if (instr_addr !== m_fa) begin mismatched++; $display("FAIL rnd_addr@%0d: got %h want %h", cyc, instr_addr, m_fa); end
      compared++; if (instr_fetch_restart !== (m_mode == M_REQ)) begin mismatched++; $display("FAIL rnd_restart@%0d: got %b want %b", cyc, instr_fetch_restart, m_mode == M_REQ); end
      compared++; if (instr_fetch_stall !== (m_q.size() == DEPTH)) begin mismatched++; $display("FAIL rnd_stall@%0d: got %b want %b", cyc, instr_fetch_stall, m_q.size() == DEPTH); end
      if (m_valid()) begin
        compared++; if (instr_out !== m_out()) begin mismatched++; $display("FAIL rnd_out@%0d: got %h want %h", cyc, instr_out, m_out()); end
        compared++; if (instr_out !== mem_instr(m_pc)) begin mismatched++; $display("FAIL rnd_stream@%0d: got %h want %h", cyc, instr_out, mem_instr(m_pc)); end
      end
      // emulated controller and decoder
      was_on = ctrl_on;
      if (pend_stop) begin instr_fetch_stopped = 1'b1; pend_stop = 1'b0; end
      if ($urandom_range(99) < 3) begin
        jump = 1'b1;
        jump_addr = ($urandom_range(3) == 0) ? 23'h7FFFFC + 23'($urandom_range(3)) : 23'($urandom);
        ctrl_on = 1'b0;
        pend_stop = was_on;
      end
      if (!jump && was_on && $urandom_range(29) == 0) begin
        instr_fetch_stopped = 1'b1; ctrl_on = 1'b0;
      end else if (was_on) begin
        if (!instr_fetch_stall && $urandom_range(2) != 0) begin
          instr_ready = 1'b1; instr_data = memf(ctrl_addr); ctrl_addr = ctrl_addr + 23'd1;
        end else if (instr_fetch_stall && $urandom_range(7) == 0) begin
          instr_ready = 1'b1; instr_data = 16'($urandom);
        end
      end
      if (!was_on && instr_fetch_restart && $urandom_range(2) == 0) begin
        instr_fetch_started = 1'b1;
        if (!jump) begin ctrl_on = 1'b1; ctrl_addr = instr_addr; end
      end
      if (!was_on && $urandom_range(9) == 0) begin
        instr_ready = 1'b1; instr_data = 16'($urandom);
      end
      if (m_valid() && $urandom_range(1) == 0) instr_take = 1'b1;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_nop32();
    test_rvc();
    test_jump_run();
    test_stall();
    test_stopped();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
